ps2_rx_frame: RTL
=================

Name: ps2_rx_frame

Overview:
- PS/2 device-to-host frame receiver; sits directly upstream of the PS/2 scancode memory block and feeds it one byte per valid frame.
- Synchronises the raw i_ps2_clk / i_ps2_data lines into the i_clk domain and glitch-filters the PS/2 clock.
- Deserialises 11-bit frames (start, 8 data LSB-first, odd parity, stop), checks them, and emits each good byte with a single-cycle strobe.

Parameters:
- SYNC_STAGES, 2, flip-flop depth of the synchroniser on both PS/2 lines (minimum 2).
- FILTER_LEN, 8, consecutive i_clk cycles the synchronised PS/2 clock must hold a new level before the filtered clock changes.
- TIMEOUT_CYCLES, 50000, i_clk cycles without a falling edge before a partial frame is aborted (used only with PS2_RX_TIMEOUT_EN).

Ports:
- i_clk  in  1  system clock; all logic on posedge.
- i_rst  in  1  synchronous reset, active-high.
- i_ps2_clk  in  1  raw PS/2 clock line, asynchronous.
- i_ps2_data  in  1  raw PS/2 data line, asynchronous.
- o_data  out  8  last correctly received byte.
- o_valid  out  1  one-cycle pulse: o_data updated this cycle.
- o_parity_err  out  1  one-cycle pulse: parity check failed.
- o_frame_err  out  1  one-cycle pulse: stop bit was 0, or timeout.
- o_busy  out  1  high while a frame is in progress (state != IDLE).

Behaviour:
- Reset: o_data=8'h00; o_valid, o_parity_err, o_frame_err, o_busy = 0; state=IDLE; bit counter, shift register and timeout counter cleared; synchroniser and filter flops set to 1 (idle line level). Reset mid-frame discards the partial frame with no error pulse.
- Synchroniser: SYNC_STAGES flops per line.
- Filter: filtered clock starts at 1. It takes the synchronised level only after that level has differed from it for FILTER_LEN consecutive cycles. Any mismatch gap restarts the count.
- fall strobe: 1 cycle, asserted on the cycle the filtered clock changes 1 to 0.
- Data sampling: the synchronised data line is sampled on fall cycles only.
- FSM states: IDLE, DATA, PARITY, STOP.
  - IDLE: on fall with data=0, go to DATA, bit count=0. On fall with data=1 (bad start bit), stay IDLE silently.
  - DATA: on each fall, shift the bit in LSB-first (first data bit ends up in bit 0). After the 8th bit, go to PARITY.
  - PARITY: on fall, latch the parity bit, go to STOP.
  - STOP: on fall, evaluate and always return to IDLE.
- Stop-bit evaluation, in priority order:
  - stop=0: o_frame_err pulses; o_data unchanged.
  - stop=1, XOR(8 data bits, parity bit)=0: o_parity_err pulses; o_data unchanged.
  - otherwise: o_data is loaded and o_valid pulses.
- Latency: o_valid / error pulse is asserted on the i_clk cycle after the stop-bit fall strobe. Pulses are exactly 1 cycle wide.
- Backpressure: none; PS/2 cannot be stalled, so the consumer must accept o_valid unconditionally. o_data holds its value between frames.
- o_busy is registered and tracks state != IDLE.
- A rising edge of the filtered clock has no effect on the FSM.
- Simultaneous events: reset wins over everything.

Optional Feature:
- Macro: PS2_RX_TIMEOUT_EN.
- Defined:
  - A counter runs while state != IDLE and clears on every fall strobe.
  - When it reaches TIMEOUT_CYCLES, the FSM returns to IDLE and o_frame_err pulses for 1 cycle. The partial byte is dropped and o_data is unchanged.
  - Counter width is $clog2(TIMEOUT_CYCLES+1).
- Undefined: no counter is generated; a partial frame waits indefinitely for further edges.

Test Plan:
- Good frame 0x1C (line bits 0,0,0,1,1,1,0,0,0,0,1), PS/2 period 20 i_clk cycles -> one o_valid pulse, o_data=8'h1C, no error pulses, o_busy falls with o_valid.
- Back-to-back frames 0xF0 (parity 1) then 0x1C -> two o_valid pulses; o_data reads 8'hF0 then 8'h1C.
- Frame 0x1C with parity bit flipped to 1 -> o_parity_err pulses once, o_valid stays 0, o_data keeps its previous value.
- Frame 0xFF with stop bit 0 -> o_frame_err pulses, no o_valid. A following good 0x00 frame (parity 1) -> o_valid with o_data=8'h00.
- Glitches on i_ps2_clk low for 3 cycles while idle (FILTER_LEN=8) -> o_busy stays 0, no pulses. i_rst asserted after 4 data bits -> all outputs 0. Next full frame 0x1C is received correctly.
- With PS2_RX_TIMEOUT_EN and TIMEOUT_CYCLES=100: stop edges after 5 bits -> exactly 100 cycles after the last fall, o_frame_err pulses and o_busy drops. Without the macro -> o_busy stays 1.

Source files
------------

// File: rtl/ps2_rx_frame.sv
// ps2_rx_frame: PS/2 device-to-host frame receiver.
// Synchronises and glitch-filters the PS/2 lines, then deserialises 11-bit
// frames (start, 8 data LSB-first, odd parity, stop). Each good byte is
// presented on o_data with a one-cycle o_valid strobe.
// Optional feature macro: PS2_RX_TIMEOUT_EN. When it is defined, a partial
// frame is aborted with o_frame_err after TIMEOUT_CYCLES cycles without a
// falling edge.
module ps2_rx_frame #(
  parameter int unsigned SYNC_STAGES    = 2,
  parameter int unsigned FILTER_LEN     = 8,
  parameter int unsigned TIMEOUT_CYCLES = 50000
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_ps2_clk,
  input  logic       i_ps2_data,
  output logic [7:0] o_data,
  output logic       o_valid,
  output logic       o_parity_err,
  output logic       o_frame_err,
  output logic       o_busy
);

  localparam int unsigned FILT_W = $clog2(FILTER_LEN + 1);

  // Elaboration-time parameter sanity checks
  if (SYNC_STAGES < 2) begin : g_bad_sync
    $error("ps2_rx_frame: SYNC_STAGES must be at least 2");
  end
  if (FILTER_LEN < 1) begin : g_bad_filter
    $error("ps2_rx_frame: FILTER_LEN must be at least 1");
  end
  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("ps2_rx_frame: TIMEOUT_CYCLES must be at least 1");
  end

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2,
    STOP   = 2'd3
  } state_t;

  logic [SYNC_STAGES-1:0] clk_sync;
  logic [SYNC_STAGES-1:0] dat_sync;
  logic                   clk_s;
  logic                   dat_s;

  logic                   filt_clk;
  logic [FILT_W-1:0]      filt_cnt;
  logic                   fall;

  state_t                 state;
  logic [2:0]             bit_cnt;
  logic [7:0]             shreg;
  logic                   par_bit;

  assign clk_s = clk_sync[SYNC_STAGES-1];
  assign dat_s = dat_sync[SYNC_STAGES-1];

  // Multi-flop synchronisers; both lines idle high
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      clk_sync <= '1;
      dat_sync <= '1;
    end else begin
      clk_sync <= {clk_sync[SYNC_STAGES-2:0], i_ps2_clk};
      dat_sync <= {dat_sync[SYNC_STAGES-2:0], i_ps2_data};
    end
  end

  // Clock glitch filter: follow the synchronised level only after it has
  // differed for FILTER_LEN consecutive cycles; emit a strobe on 1->0
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      filt_clk <= 1'b1;
      filt_cnt <= '0;
      fall     <= 1'b0;
    end else begin
      fall <= 1'b0;
      if (clk_s != filt_clk) begin
        if (filt_cnt == FILT_W'(FILTER_LEN - 1)) begin
          filt_clk <= clk_s;
          filt_cnt <= '0;
          fall     <= filt_clk;
        end else begin
          filt_cnt <= filt_cnt + 1'b1;
        end
      end else begin
        filt_cnt <= '0;
      end
    end
  end

`ifdef PS2_RX_TIMEOUT_EN
  localparam int unsigned TO_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TO_W-1:0] to_cnt;
`endif

  // Frame FSM: deserialise on fall strobes, check and publish on the stop bit
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state        <= IDLE;
      bit_cnt      <= '0;
      shreg        <= '0;
      par_bit      <= 1'b0;
      o_data       <= '0;
      o_valid      <= 1'b0;
      o_parity_err <= 1'b0;
      o_frame_err  <= 1'b0;
      o_busy       <= 1'b0;
`ifdef PS2_RX_TIMEOUT_EN
      to_cnt       <= '0;
`endif
    end else begin
      o_valid      <= 1'b0;
      o_parity_err <= 1'b0;
      o_frame_err  <= 1'b0;

      case (state)
        IDLE: begin
          // A high start bit is ignored silently
          if (fall && !dat_s) begin
            state   <= DATA;
            bit_cnt <= '0;
            o_busy  <= 1'b1;
          end
        end
        DATA: begin
          if (fall) begin
            shreg   <= {dat_s, shreg[7:1]};
            bit_cnt <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) begin
              state <= PARITY;
            end
          end
        end
        PARITY: begin
          if (fall) begin
            par_bit <= dat_s;
            state   <= STOP;
          end
        end
        STOP: begin
          if (fall) begin
            state  <= IDLE;
            o_busy <= 1'b0;
            if (!dat_s) begin
              o_frame_err <= 1'b1;
            end else if (^{shreg, par_bit} == 1'b0) begin
              o_parity_err <= 1'b1;
            end else begin
              o_data  <= shreg;
              o_valid <= 1'b1;
            end
          end
        end
        default: begin
          state  <= IDLE;
          o_busy <= 1'b0;
        end
      endcase

`ifdef PS2_RX_TIMEOUT_EN
      // Abort a stalled partial frame; never coincides with a fall strobe
      if (state == IDLE || fall) begin
        to_cnt <= '0;
      end else if (to_cnt == TO_W'(TIMEOUT_CYCLES - 1)) begin
        to_cnt      <= '0;
        state       <= IDLE;
        o_busy      <= 1'b0;
        o_frame_err <= 1'b1;
      end else begin
        to_cnt <= to_cnt + 1'b1;
      end
`endif
    end
  end

endmodule
